// File: rtl/epsilon_stage_if.sv
// Sample bus between the delta stage and the epsilon low-pass stage.
// Latency: none, wires only.
// Backpressure: none; one sample per clock in each direction, no handshake.
interface epsilon_stage_if;
    logic signed [19:0] D_out;
    logic signed [19:0] E_out;

    // Upstream/bench side: drives samples, observes the filtered result.
    modport master (
        output D_out,
        input  E_out
    );

    // Filter side: consumes samples, produces the filtered result.
    modport slave (
        input  D_out,
        output E_out
    );
endinterface

// File: rtl/epsilon_stage.sv
// 4-tap 1-2-2-1 low-pass FIR on a 20-bit signed stream, divided by 4 and saturated to 20 bits.
// Latency: a sample at edge k first reaches E_out after edge k+1; last contribution after edge k+4.
// Backpressure: none; a sample is taken and a result produced on every rising edge.
module epsilon_stage (
    input  logic            clk,
    input  logic            reset,
    epsilon_stage_if.slave  bus
);
    localparam logic signed [22:0] SAT_MAX = 23'sd524287;
    localparam logic signed [22:0] SAT_MIN = -23'sd524288;

    logic signed [19:0] x0, x1, x2, x3;
    logic signed [19:0] e_reg;
    logic signed [22:0] sum;
    logic signed [22:0] quo;
    logic signed [19:0] sat;

    // Delay line: shift one new sample in per edge; reset wipes all history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0 <= '0;
            x1 <= '0;
            x2 <= '0;
            x3 <= '0;
        end else begin
            x0 <= bus.D_out;
            x1 <= x0;
            x2 <= x1;
            x3 <= x2;
        end
    end

    // Weighted sum (sign-extended to 23 bits, cannot overflow), floor-divide by 4, clamp to 20 bits.
    always_comb begin
        sum = {{3{x0[19]}}, x0}
            + {{2{x1[19]}}, x1, 1'b0}
            + {{2{x2[19]}}, x2, 1'b0}
            + {{3{x3[19]}}, x3};
        quo = sum >>> 2;
        sat = quo[19:0];
        if (quo > SAT_MAX) begin
            sat = SAT_MAX[19:0];
        end else if (quo < SAT_MIN) begin
            sat = SAT_MIN[19:0];
        end
    end

    // Output register so E_out comes straight from a flop and is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_reg <= '0;
        end else begin
            e_reg <= sat;
        end
    end

    assign bus.E_out = e_reg;
endmodule

// File: tb/tb_epsilon_stage.sv
// Directed and random checks of the epsilon low-pass stage.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none; the bench drives a new sample every cycle.
module tb_epsilon_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    epsilon_stage_if bus ();

    epsilon_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Apply one sample, let one rising edge take it, return 1 ns after the edge.
    task automatic step(input int d);
        bus.D_out = 20'(d);
        @(posedge clk);
        #1;
    endtask

    // Synchronous-looking reset pulse spanning one rising edge; released 1 ns after it.
    task automatic do_reset();
        reset = 1'b1;
        bus.D_out = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Run a 6-sample directed vector right after a reset and compare every edge.
    task automatic run_vec(input string tag, input int din[6], input int exp_e[6]);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(din[i]);
            check_eq($sformatf("%s[%0d]", tag, i + 1), int'(bus.E_out), exp_e[i]);
        end
    endtask

    function automatic int sat20(input int v);
        if (v > 524287) return 524287;
        if (v < -524288) return -524288;
        return v;
    endfunction

    initial begin
        int m0, m1, m2, m3, exp_e, d;
        n_checks = 0;
        n_fail   = 0;

        // Reset held with a non-zero input: everything stays at zero.
        reset = 1'b1;
        bus.D_out = 20'sd123456;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_e",  int'(bus.E_out), 0);
        check_eq("rst_x0", int'(dut.x0), 0);
        check_eq("rst_x1", int'(dut.x1), 0);
        check_eq("rst_x2", int'(dut.x2), 0);
        check_eq("rst_x3", int'(dut.x3), 0);
        reset = 1'b0;

        // Impulse of 4 at edge 1.
        run_vec("impulse", '{4, 0, 0, 0, 0, 0}, '{0, 1, 2, 2, 1, 0});
        // Floor rounding: +6/4 -> 1, -6/4 -> -2.
        run_vec("dc_p1",   '{1, 1, 1, 1, 1, 1}, '{0, 0, 0, 1, 1, 1});
        run_vec("dc_m1",   '{-1, -1, -1, -1, -1, -1}, '{0, -1, -1, -2, -2, -2});
        // Saturation at both rails.
        run_vec("sat_pos", '{524287, 524287, 524287, 524287, 524287, 524287},
                           '{0, 131071, 393215, 524287, 524287, 524287});
        run_vec("sat_neg", '{-524288, -524288, -524288, -524288, -524288, -524288},
                           '{0, -131072, -393216, -524288, -524288, -524288});

        // Mid-stream reset: E_out clears immediately without a clock edge.
        do_reset();
        for (int i = 0; i < 10; i++) step(200000);
        check_eq("mid_pre", int'(bus.E_out), 300000);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_async_e",  int'(bus.E_out), 0);
        check_eq("mid_async_x3", int'(dut.x3), 0);
        @(negedge clk);
        bus.D_out = '0;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0);
            check_eq($sformatf("mid_post[%0d]", i + 1), int'(bus.E_out), 0);
        end

        // Random soak against a reference model of the filter.
        do_reset();
        m0 = 0; m1 = 0; m2 = 0; m3 = 0;
        for (int i = 0; i < 1000; i++) begin
            d = int'($urandom_range(524287, 0));
            exp_e = sat20((m0 + 2 * m1 + 2 * m2 + m3) >>> 2);
            m3 = m2; m2 = m1; m1 = m0; m0 = d;
            step(d);
            check_eq($sformatf("soak[%0d]", i), int'(bus.E_out), exp_e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
